alu_issue_ctrl: RTL

//   Issue-side controller for the combinational 32-bit ALU. It accepts one decoded operation per

---
 rtl/alu_issue_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for a combinational 32-bit ALU.
// It accepts one op per handshake, runs one or two ALU passes, and returns the
// result and flag over a valid/ready channel. SUB and the equality compares
// negate B on the first pass, then add A to the negated value on the second.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for in_valid; in_ready=1
// P1     | first ALU pass; operands and controls come from the accepted op
// P2     | second pass of SUB/BEQ/BNE: in1=A, in2=-B, plain add
// DONE   | result held on out_*; leaves on out_ready
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [1:0]        alu_op,
  output logic [2:0]        alu_setflag,
  output logic              alu_lor,
  output logic              alu_arith,
  output logic              alu_twoc,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_flag,
  output logic              out_illegal
);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_NEG  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BLTZ = OP_W'(10);
  localparam logic [OP_W-1:0] OP_BGEZ = OP_W'(11);
  localparam logic [OP_W-1:0] OP_ILL0 = OP_W'(12);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_P1   = 2'd1,
    S_P2   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [1:0]        aop_q, aop_d;
  logic [2:0]        setflag_q, setflag_d;
  logic              lor_q, lor_d, arith_q, arith_d, twoc_q, twoc_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              flag_q, flag_d, ill_q, ill_d;

  logic              two_pass_q;
  logic              flag_op_q;

  assign two_pass_q = (op_q == OP_SUB) || (op_q == OP_BEQ) || (op_q == OP_BNE);
  // Only the compare/branch ops report the ALU flag; others return 0.
  assign flag_op_q  = (op_q >= OP_BEQ) && (op_q < OP_ILL0);

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      aop_q     <= 2'b00;
      setflag_q <= 3'b000;
      lor_q     <= 1'b0;
      arith_q   <= 1'b0;
      twoc_q    <= 1'b0;
      res_q     <= '0;
      flag_q    <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      aop_q     <= aop_d;
      setflag_q <= setflag_d;
      lor_q     <= lor_d;
      arith_q   <= arith_d;
      twoc_q    <= twoc_d;
      res_q     <= res_d;
      flag_q    <= flag_d;
      ill_q     <= ill_d;
    end
  end

  // Next-state, pass sequencing and result capture.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    aop_d     = aop_q;
    setflag_d = setflag_q;
    lor_d     = lor_q;
    arith_d   = arith_q;
    twoc_d    = twoc_q;
    res_d     = res_q;
    flag_d    = flag_q;
    ill_d     = ill_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = in_op;
          if (in_op >= OP_ILL0) begin
            // Unassigned op: skip the ALU entirely, ALU controls untouched.
            state_d = S_DONE;
            res_d   = '0;
            flag_d  = 1'b0;
            ill_d   = 1'b1;
          end else begin
            state_d   = S_P1;
            ill_d     = 1'b0;
            in1_d     = in_a;
            in2_d     = in_b;
            aop_d     = 2'b00;
            setflag_d = 3'b000;
            lor_d     = 1'b0;
            arith_d   = 1'b0;
            twoc_d    = 1'b0;
            case (in_op)
              OP_SUB, OP_NEG, OP_BEQ, OP_BNE: twoc_d = 1'b1;
              OP_AND: aop_d = 2'b01;
              OP_OR:  aop_d = 2'b10;
              OP_SLL: aop_d = 2'b11;
              OP_SRL: begin
                aop_d = 2'b11;
                lor_d = 1'b1;
              end
              OP_SRA: begin
                aop_d   = 2'b11;
                lor_d   = 1'b1;
                arith_d = 1'b1;
              end
              OP_BLTZ: begin
                in2_d     = '0;
                setflag_d = 3'b011;
              end
              OP_BGEZ: begin
                in2_d     = '0;
                setflag_d = 3'b100;
              end
              default: ;
            endcase
          end
        end
      end
      S_P1: begin
        if (two_pass_q) begin
          // Negated B becomes in2 of the add pass; in1 still holds A.
          in2_d   = alu_result;
          twoc_d  = 1'b0;
          state_d = S_P2;
          if (op_q == OP_BEQ)      setflag_d = 3'b001;
          else if (op_q == OP_BNE) setflag_d = 3'b010;
          else                     setflag_d = 3'b000;
        end else begin
          res_d     = alu_result;
          flag_d    = flag_op_q & alu_zero;
          setflag_d = 3'b000;
          state_d   = S_DONE;
        end
      end
      S_P2: begin
        res_d     = alu_result;
        flag_d    = flag_op_q & alu_zero;
        setflag_d = 3'b000;
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign out_result  = res_q;
  assign out_flag    = flag_q;
  assign out_illegal = ill_q;
  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;
  assign alu_op      = aop_q;
  assign alu_setflag = setflag_q;
  assign alu_lor     = lor_q;
  assign alu_arith   = arith_q;
  assign alu_twoc    = twoc_q;

endmodule
